execute_stage: RTL
==================

# execute_stage

Execute stage of the five-stage RV32IM pipeline: consumes the decode/execute pipeline register outputs, applies operand forwarding, and computes the ALU result, branch/jump decision and target. It runs DIV/DIVU/REM/REMU on an iterative radix-2 divider, holding the pipeline with a stall while the divide runs. Results are registered into the execute/memory boundary, so this block also owns the EX/MEM register.

## Interface
- No parameters; XLEN fixed at 32.
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- de_valid_i  in  1  decode/execute slot holds a real instruction
- de_opcode_i  in  7  opcode
- de_funct3_i  in  3  funct3
- de_funct7_i  in  7  funct7 (bit 5: SUB/SRA; 0000001: M-ext)
- de_pc_i  in  32  instruction PC
- de_rd_i  in  5  destination register
- de_read_data1_i, de_read_data2_i  in  32  register-file operands
- de_offset_i  in  32  sign-extended immediate
- de_alusrc_i, de_mem_to_reg_i, de_reg_write_i, de_mem_read_i, de_mem_write_i, de_jump_i  in  1  control
- de_alu_op_i  in  2  00 add, 01 branch compare, 10 funct-decoded, 11 LUI/AUIPC/JAL/JALR
- fwd_a_sel_i, fwd_b_sel_i  in  2  00 register file, 01 mem_fwd_data_i, 10 wb_fwd_data_i, 11 reserved (treated as 00)
- mem_fwd_data_i, wb_fwd_data_i  in  32  forwarded results
- ex_stall_o  out  1  hold fetch/decode and the decode/execute register
- branch_taken_o  out  1  redirect fetch; flush younger stages (combinational)
- branch_target_o  out  32  redirect address (combinational)
- em_valid_o, em_reg_write_o, em_mem_to_reg_o, em_mem_read_o, em_mem_write_o  out  1  registered control
- em_alu_result_o  out  32  registered result or memory address
- em_store_data_o  out  32  forwarded operand B (registered)
- em_rd_o  out  5, em_funct3_o  out  3  registered

## Operation
- Operand A = fwd_a_sel_i mux. Operand B (fwd) = fwd_b_sel_i mux. ALU B = de_offset_i if de_alusrc_i, else operand B (fwd).
- ALU ops:
  - alu_op 10: ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND by funct3/funct7[5]. Shift amount is B[4:0].
  - alu_op 11: LUI → imm; AUIPC → pc+imm; JAL/JALR → pc+4.
- M-extension multiply: MUL/MULH/MULHSU/MULHU complete in one cycle using a 33x33 signed product.
- M-extension divide: DIV/DIVU/REM/REMU go to the divider FSM.
- Branches (opcode 1100011, alu_op 01):
  - Conditions: BEQ, BNE, BLT, BGE, BLTU, BGEU.
  - branch_taken_o = valid && !ex_stall_o && condition.
  - Target = pc+offset.
- Jumps: branch_taken_o = 1 when de_jump_i. JAL target = pc+offset. JALR target = (A+offset) & ~1.
- Bubble: when de_valid_i=0, em_valid_o and all em_* write/read enables register as 0. Data fields are don't-care but registered.
- Divider FSM states:
  - IDLE: valid divide not special → load operands and magnitudes, count=0, go to BUSY. ex_stall_o=1.
  - BUSY: one restoring step per cycle; count increments. When count=31 at the edge, go to DONE. ex_stall_o=1.
  - DONE: sign-fix the result, drive it to the EX/MEM register with em_valid=1. ex_stall_o=0. Go to IDLE.
- Special divides resolve in IDLE in one cycle, no stall:
  - Divide by zero: quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- While ex_stall_o=1 the EX/MEM register loads a bubble (em_valid_o=0). Upstream holds de_* stable.

## Timing
- Reset: all em_* outputs 0; FSM in IDLE; ex_stall_o=0. rst_i mid-divide aborts the divide and the result is discarded.
- Non-divide instruction in cycle N → em_* valid in cycle N+1.
- Divide presented in cycle N:
  - ex_stall_o=1 in cycles N..N+32.
  - DONE in cycle N+33.
  - em_valid_o=1 with the result in cycle N+34.
- branch_taken_o is never asserted in a cycle where ex_stall_o=1.
- de_valid_i=0 in IDLE never starts the FSM.

## Structure
- pipeline_pkg: opcode constants, alu_op encodings, fwd_sel encodings, M-extension funct3 codes, divider state typedef.
- Sub-module serial_divider:
  - Contains the FSM, unsigned restoring core and sign fix-up.
  - Ports: start, signed_op, rem_op, a, b, busy, done, result.
- Forwarding mux, ALU, branch compare and EX/MEM register stay in execute_stage.

## Test plan
- ADD with fwd_a_sel=01 (mem_fwd_data_i=5) and read_data2=7 → next cycle em_alu_result_o=12, em_reg_write_o=1.
- BLT with A=-1, B=1 → branch_taken_o=1, target=pc+offset. Same operands with BLTU → branch_taken_o=0.
- DIV -7/2 → ex_stall_o high for 33 cycles, then em_alu_result_o=0xFFFFFFFD. REM -7/2 → 0xFFFFFFFF.
- DIVU 9/0 → single cycle, no stall, result 0xFFFFFFFF. REM 0x80000000 / -1 → 0.
- rst_i asserted at divide cycle 10 → next cycle ex_stall_o=0 and em_valid_o=0; a following ADD completes normally.
- de_valid_i=0 with mem_write=1 → em_mem_write_o=0 and em_valid_o=0.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared encodings for the RV32IM execute stage: opcodes, ALU/forwarding
// selectors, M-extension funct3 codes and the divider state type.
package pipeline_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_UPPER  = 2'b11;

    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [6:0] F7_MEXT   = 7'b0000001;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Two's-complement negate when neg is set.
    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode/execute inputs and EX/MEM register outputs of the execute stage.
interface execute_stage_if;
    logic        de_valid_i;
    logic [6:0]  de_opcode_i;
    logic [2:0]  de_funct3_i;
    logic [6:0]  de_funct7_i;
    logic [31:0] de_pc_i;
    logic [4:0]  de_rd_i;
    logic [31:0] de_read_data1_i;
    logic [31:0] de_read_data2_i;
    logic [31:0] de_offset_i;
    logic        de_alusrc_i;
    logic        de_mem_to_reg_i;
    logic        de_reg_write_i;
    logic        de_mem_read_i;
    logic        de_mem_write_i;
    logic        de_jump_i;
    logic [1:0]  de_alu_op_i;

    logic        em_valid_o;
    logic        em_reg_write_o;
    logic        em_mem_to_reg_o;
    logic        em_mem_read_o;
    logic        em_mem_write_o;
    logic [31:0] em_alu_result_o;
    logic [31:0] em_store_data_o;
    logic [4:0]  em_rd_o;
    logic [2:0]  em_funct3_o;

    modport master (
        output de_valid_i, de_opcode_i, de_funct3_i, de_funct7_i, de_pc_i, de_rd_i,
               de_read_data1_i, de_read_data2_i, de_offset_i, de_alusrc_i,
               de_mem_to_reg_i, de_reg_write_i, de_mem_read_i, de_mem_write_i,
               de_jump_i, de_alu_op_i,
        input  em_valid_o, em_reg_write_o, em_mem_to_reg_o, em_mem_read_o,
               em_mem_write_o, em_alu_result_o, em_store_data_o, em_rd_o, em_funct3_o
    );

    modport slave (
        input  de_valid_i, de_opcode_i, de_funct3_i, de_funct7_i, de_pc_i, de_rd_i,
               de_read_data1_i, de_read_data2_i, de_offset_i, de_alusrc_i,
               de_mem_to_reg_i, de_reg_write_i, de_mem_read_i, de_mem_write_i,
               de_jump_i, de_alu_op_i,
        output em_valid_o, em_reg_write_o, em_mem_to_reg_o, em_mem_read_o,
               em_mem_write_o, em_alu_result_o, em_store_data_o, em_rd_o, em_funct3_o
    );
endinterface

// File: rtl/serial_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle over 32 BUSY cycles,
// operands held as magnitudes, sign applied in DONE.
module serial_divider
    import pipeline_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start,
    input  logic        signed_op,
    input  logic        rem_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state_q;
    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        rem_op_q;

    logic [32:0] shifted_s;
    logic [32:0] diff_s;

    assign shifted_s = {rem_q, quo_q[31]};
    assign diff_s    = shifted_s - {1'b0, dvs_q};

    // Divider FSM: load magnitudes, iterate the restoring step, hand off the result.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DIV_IDLE;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvs_q     <= 32'd0;
            cnt_q     <= 5'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_op_q  <= 1'b0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        rem_q     <= 32'd0;
                        quo_q     <= neg_if(a, signed_op & a[31]);
                        dvs_q     <= neg_if(b, signed_op & b[31]);
                        cnt_q     <= 5'd0;
                        neg_quo_q <= signed_op & (a[31] ^ b[31]);
                        neg_rem_q <= signed_op & a[31];
                        rem_op_q  <= rem_op;
                        state_q   <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (!diff_s[32]) begin
                        rem_q <= diff_s[31:0];
                        quo_q <= {quo_q[30:0], 1'b1};
                    end else begin
                        rem_q <= shifted_s[31:0];
                        quo_q <= {quo_q[30:0], 1'b0};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    state_q <= DIV_IDLE;
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == DIV_BUSY);
    assign done   = (state_q == DIV_DONE);
    assign result = rem_op_q ? neg_if(rem_q, neg_rem_q) : neg_if(quo_q, neg_quo_q);

endmodule

// File: rtl/execute_stage.sv
// RV32IM execute stage: forwarding, ALU, single-cycle multiply, branch
// resolution, serial divide with pipeline stall, and the EX/MEM register.
module execute_stage
    import pipeline_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        fwd_a_sel_i,
    input  logic [1:0]        fwd_b_sel_i,
    input  logic [31:0]       mem_fwd_data_i,
    input  logic [31:0]       wb_fwd_data_i,
    output logic              ex_stall_o,
    output logic              branch_taken_o,
    output logic [31:0]       branch_target_o,
    execute_stage_if.slave    bus
);

    logic [31:0] op_a_s, op_b_s, alu_b_s, alu_res_s, mul_res_s, special_res_s;
    logic [32:0] mul_a_s, mul_b_s;
    logic [65:0] mul_prod_s;
    logic [1:0]  unused_prod_s;
    logic        is_mext_s, is_div_s, div_signed_s, div_special_s, cond_s;
    logic        div_start_s, div_busy_s, div_done_s;
    logic [31:0] div_res_s;

    logic        em_valid_d, em_valid_q, em_reg_write_d, em_reg_write_q;
    logic        em_mem_to_reg_d, em_mem_to_reg_q, em_mem_read_d, em_mem_read_q;
    logic        em_mem_write_d, em_mem_write_q;
    logic [31:0] em_alu_result_d, em_alu_result_q, em_store_data_d, em_store_data_q;
    logic [4:0]  em_rd_d, em_rd_q;
    logic [2:0]  em_funct3_d, em_funct3_q;

    // Operand forwarding; the reserved selector falls back to the register file.
    always_comb begin
        case (fwd_a_sel_i)
            FWD_MEM: op_a_s = mem_fwd_data_i;
            FWD_WB:  op_a_s = wb_fwd_data_i;
            default: op_a_s = bus.de_read_data1_i;
        endcase
        case (fwd_b_sel_i)
            FWD_MEM: op_b_s = mem_fwd_data_i;
            FWD_WB:  op_b_s = wb_fwd_data_i;
            default: op_b_s = bus.de_read_data2_i;
        endcase
        alu_b_s = bus.de_alusrc_i ? bus.de_offset_i : op_b_s;
    end

    assign is_mext_s    = (bus.de_alu_op_i == ALU_FUNCT) && (bus.de_opcode_i == OPC_OP) &&
                          (bus.de_funct7_i == F7_MEXT);
    assign is_div_s     = bus.de_valid_i && is_mext_s && bus.de_funct3_i[2];
    assign div_signed_s = ~bus.de_funct3_i[0];

    // 33x33 signed product; bit 32 of each operand carries its sign or a zero.
    assign mul_a_s       = {((bus.de_funct3_i == F3_MULH) || (bus.de_funct3_i == F3_MULHSU)) & op_a_s[31], op_a_s};
    assign mul_b_s       = {(bus.de_funct3_i == F3_MULH) & alu_b_s[31], alu_b_s};
    assign mul_prod_s    = $signed(mul_a_s) * $signed(mul_b_s);
    assign unused_prod_s = mul_prod_s[65:64];

    // Multiply result select and the divides that resolve without the serial core.
    always_comb begin
        if (bus.de_funct3_i == F3_MULH || bus.de_funct3_i == F3_MULHSU || bus.de_funct3_i == F3_MULHU) begin
            mul_res_s = mul_prod_s[63:32];
        end else begin
            mul_res_s = mul_prod_s[31:0];
        end
        if (alu_b_s == 32'd0) begin
            div_special_s = 1'b1;
            special_res_s = bus.de_funct3_i[1] ? op_a_s : 32'hFFFF_FFFF;
        end else if (div_signed_s && (op_a_s == 32'h8000_0000) && (alu_b_s == 32'hFFFF_FFFF)) begin
            div_special_s = 1'b1;
            special_res_s = bus.de_funct3_i[1] ? 32'd0 : 32'h8000_0000;
        end else begin
            div_special_s = 1'b0;
            special_res_s = 32'd0;
        end
    end

    assign div_start_s = is_div_s && !div_special_s && !div_busy_s && !div_done_s;
    assign ex_stall_o  = div_start_s || div_busy_s;

    serial_divider u_div (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start     (div_start_s),
        .signed_op (div_signed_s),
        .rem_op    (bus.de_funct3_i[1]),
        .a         (op_a_s),
        .b         (alu_b_s),
        .busy      (div_busy_s),
        .done      (div_done_s),
        .result    (div_res_s)
    );

    // Main ALU result by alu_op class.
    always_comb begin
        alu_res_s = 32'd0;
        case (bus.de_alu_op_i)
            ALU_ADD:    alu_res_s = op_a_s + alu_b_s;
            ALU_BRANCH: alu_res_s = op_a_s - alu_b_s;
            ALU_FUNCT: begin
                if (is_mext_s) begin
                    alu_res_s = bus.de_funct3_i[2] ? special_res_s : mul_res_s;
                end else begin
                    case (bus.de_funct3_i)
                        3'b000: alu_res_s = (bus.de_opcode_i == OPC_OP && bus.de_funct7_i[5]) ?
                                            op_a_s - alu_b_s : op_a_s + alu_b_s;
                        3'b001: alu_res_s = op_a_s << alu_b_s[4:0];
                        3'b010: alu_res_s = {31'd0, $signed(op_a_s) < $signed(alu_b_s)};
                        3'b011: alu_res_s = {31'd0, op_a_s < alu_b_s};
                        3'b100: alu_res_s = op_a_s ^ alu_b_s;
                        3'b101: alu_res_s = bus.de_funct7_i[5] ? 32'($signed(op_a_s) >>> alu_b_s[4:0]) :
                                            op_a_s >> alu_b_s[4:0];
                        3'b110: alu_res_s = op_a_s | alu_b_s;
                        default: alu_res_s = op_a_s & alu_b_s;
                    endcase
                end
            end
            default: begin
                if (bus.de_opcode_i == OPC_LUI) begin
                    alu_res_s = bus.de_offset_i;
                end else if (bus.de_opcode_i == OPC_AUIPC) begin
                    alu_res_s = bus.de_pc_i + bus.de_offset_i;
                end else begin
                    alu_res_s = bus.de_pc_i + 32'd4;
                end
            end
        endcase
    end

    // Branch condition, redirect decision and target.
    always_comb begin
        case (bus.de_funct3_i)
            F3_BEQ:  cond_s = (op_a_s == op_b_s);
            F3_BNE:  cond_s = (op_a_s != op_b_s);
            F3_BLT:  cond_s = ($signed(op_a_s) < $signed(op_b_s));
            F3_BGE:  cond_s = ($signed(op_a_s) >= $signed(op_b_s));
            F3_BLTU: cond_s = (op_a_s < op_b_s);
            F3_BGEU: cond_s = (op_a_s >= op_b_s);
            default: cond_s = 1'b0;
        endcase
        branch_taken_o = bus.de_valid_i && !ex_stall_o &&
                         (bus.de_jump_i || ((bus.de_opcode_i == OPC_BRANCH) && cond_s));
        if (bus.de_jump_i && (bus.de_opcode_i == OPC_JALR)) begin
            branch_target_o = (op_a_s + bus.de_offset_i) & 32'hFFFF_FFFE;
        end else begin
            branch_target_o = bus.de_pc_i + bus.de_offset_i;
        end
    end

    // EX/MEM next state: bubble while stalled, divider result when it finishes.
    always_comb begin
        em_valid_d      = bus.de_valid_i;
        em_reg_write_d  = bus.de_valid_i & bus.de_reg_write_i;
        em_mem_to_reg_d = bus.de_valid_i & bus.de_mem_to_reg_i;
        em_mem_read_d   = bus.de_valid_i & bus.de_mem_read_i;
        em_mem_write_d  = bus.de_valid_i & bus.de_mem_write_i;
        em_alu_result_d = alu_res_s;
        em_store_data_d = op_b_s;
        em_rd_d         = bus.de_rd_i;
        em_funct3_d     = bus.de_funct3_i;
        if (ex_stall_o) begin
            em_valid_d      = 1'b0;
            em_reg_write_d  = 1'b0;
            em_mem_to_reg_d = 1'b0;
            em_mem_read_d   = 1'b0;
            em_mem_write_d  = 1'b0;
        end else if (div_done_s) begin
            em_alu_result_d = div_res_s;
        end else begin
            em_alu_result_d = alu_res_s;
        end
    end

    // EX/MEM register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            em_valid_q      <= 1'b0;
            em_reg_write_q  <= 1'b0;
            em_mem_to_reg_q <= 1'b0;
            em_mem_read_q   <= 1'b0;
            em_mem_write_q  <= 1'b0;
            em_alu_result_q <= 32'd0;
            em_store_data_q <= 32'd0;
            em_rd_q         <= 5'd0;
            em_funct3_q     <= 3'd0;
        end else begin
            em_valid_q      <= em_valid_d;
            em_reg_write_q  <= em_reg_write_d;
            em_mem_to_reg_q <= em_mem_to_reg_d;
            em_mem_read_q   <= em_mem_read_d;
            em_mem_write_q  <= em_mem_write_d;
            em_alu_result_q <= em_alu_result_d;
            em_store_data_q <= em_store_data_d;
            em_rd_q         <= em_rd_d;
            em_funct3_q     <= em_funct3_d;
        end
    end

    assign bus.em_valid_o      = em_valid_q;
    assign bus.em_reg_write_o  = em_reg_write_q;
    assign bus.em_mem_to_reg_o = em_mem_to_reg_q;
    assign bus.em_mem_read_o   = em_mem_read_q;
    assign bus.em_mem_write_o  = em_mem_write_q;
    assign bus.em_alu_result_o = em_alu_result_q;
    assign bus.em_store_data_o = em_store_data_q;
    assign bus.em_rd_o         = em_rd_q;
    assign bus.em_funct3_o     = em_funct3_q;

endmodule
